// File: rtl/seg_pattern_rx.sv
// Seven-segment pattern receiver: debounces segs_in, decodes stable patterns into class codes
// and hands them over through a valid/ready register. Optional SEGRX_ERRCNT_EN adds err_count.
module seg_pattern_rx #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] segs_in,
    input  logic       out_ready,
    output logic       code_valid,
    output logic [2:0] code,
    output logic       code_invalid,
    output logic       overflow
`ifdef SEGRX_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic {S_WAIT, S_ARMED} state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? lim : v + 8'd1;
    endfunction

    // Returns {invalid, code}.
    function automatic logic [3:0] decode(input logic [6:0] p);
        case (p)
            7'h3C:   return 4'b0_000;
            7'h6E:   return 4'b0_001;
            7'h4F:   return 4'b0_010;
            7'h5B:   return 4'b0_011;
            7'h6F:   return 4'b0_100;
            default: return 4'b1_111;
        endcase
    endfunction

    state_t      state, state_next;
    logic [6:0]  seg_q;
    logic [7:0]  cnt, cnt_next;
    logic [6:0]  last_rep;
    logic        reported;
    logic        seg_diff, reach, accept;
    logic        evt_vld_p1;
    logic [2:0]  evt_code_p1;
    logic        evt_inv_p1;

    assign seg_diff = (segs_in != seg_q);
    assign cnt_next = seg_diff ? 8'd1 : sat_inc(cnt, STABLE);
    assign reach    = !seg_diff && (cnt_next == STABLE) && (cnt != STABLE);

    // Stage p0: sampling, stability counter and acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_WAIT;
            seg_q    <= 7'd0;
            cnt      <= 8'd0;
            reported <= 1'b0;
        end else begin
            state <= state_next;
            seg_q <= segs_in;
            cnt   <= cnt_next;
            if (accept) begin
                reported <= 1'b1;
                last_rep <= seg_q;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (seg_diff)
            state_next = S_WAIT;
        else if (cnt_next == STABLE)
            state_next = S_ARMED;
    end

    always_comb begin
        accept = 1'b0;
        if (state == S_WAIT && reach && (!reported || seg_q != last_rep))
            accept = 1'b1;
    end

    // Stage p1: decoded event awaiting the output register
    always_ff @(posedge clk) begin
        if (rst)
            evt_vld_p1 <= 1'b0;
        else
            evt_vld_p1 <= accept;
    end

    always_ff @(posedge clk) begin
        {evt_inv_p1, evt_code_p1} <= decode(seg_q);
    end

    // Stage p2: handshake output register; a busy register drops the event and flags overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            code_valid   <= 1'b0;
            code         <= 3'd0;
            code_invalid <= 1'b0;
            overflow     <= 1'b0;
        end else if (evt_vld_p1) begin
            if (!code_valid || out_ready) begin
                code_valid   <= 1'b1;
                code         <= evt_code_p1;
                code_invalid <= evt_inv_p1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (code_valid && out_ready) begin
            code_valid <= 1'b0;
        end
    end

`ifdef SEGRX_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_count <= 8'd0;
        else if (evt_vld_p1 && evt_inv_p1)
            err_count <= sat_inc(err_count, 8'd255);
    end
`endif

endmodule

// File: tb/tb_seg_pattern_rx.sv
// Directed bench for seg_pattern_rx (STABLE_CYCLES=4); covers err_count when SEGRX_ERRCNT_EN is defined.
module tb_seg_pattern_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] segs_in;
    logic       out_ready;
    logic       code_valid;
    logic [2:0] code;
    logic       code_invalid;
    logic       overflow;
`ifdef SEGRX_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    seg_pattern_rx #(.STABLE_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .segs_in      (segs_in),
        .out_ready    (out_ready),
        .code_valid   (code_valid),
        .code         (code),
        .code_invalid (code_invalid),
        .overflow     (overflow)
`ifdef SEGRX_ERRCNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] c, input logic inv);
        chk({tag, "_valid"}, {7'd0, code_valid}, {7'd0, v});
        chk({tag, "_code"}, {5'd0, code}, {5'd0, c});
        chk({tag, "_inv"}, {7'd0, code_invalid}, {7'd0, inv});
    endtask

    task automatic wait_quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk(tag, {7'd0, code_valid}, 8'd0);
        end
    endtask

    initial begin
        rst = 1'b1; segs_in = 7'h00; out_ready = 1'b1;
        step(); step();
        chk_out("reset", 1'b0, 3'd0, 1'b0);
        chk("reset_ovf", {7'd0, overflow}, 8'd0);
`ifdef SEGRX_ERRCNT_EN
        chk("reset_errcnt", err_count, 8'd0);
`endif

        // Hold 0x5B: valid after the 5th edge, one cycle only
        rst = 1'b0; segs_in = 7'h5B;
        wait_quiet("h5b_wait", 4);
        step(); chk_out("h5b_evt", 1'b1, 3'd3, 1'b0);
        wait_quiet("h5b_held", 8);

        // Glitch inside the stabilisation window restarts the count
        segs_in = 7'h3C; wait_quiet("h3c_pre", 3);
        segs_in = 7'h6E; wait_quiet("h6e_glitch", 1);
        segs_in = 7'h3C; wait_quiet("h3c_wait", 4);
        step(); chk_out("h3c_evt", 1'b1, 3'd0, 1'b0);
        wait_quiet("h3c_done", 2);

        // Back-pressure: 0x4F held, 0x6F dropped with overflow
        out_ready = 1'b0; segs_in = 7'h4F;
        wait_quiet("h4f_wait", 4);
        step(); chk_out("h4f_evt", 1'b1, 3'd2, 1'b0);
        segs_in = 7'h6F;
        for (int i = 0; i < 4; i++) begin
            step(); chk_out("h4f_hold", 1'b1, 3'd2, 1'b0);
            chk("h4f_noovf", {7'd0, overflow}, 8'd0);
        end
        step(); chk_out("h6f_drop", 1'b1, 3'd2, 1'b0);
        chk("h6f_ovf", {7'd0, overflow}, 8'd1);
        step(); step(); chk_out("h4f_stall", 1'b1, 3'd2, 1'b0);
        out_ready = 1'b1;
        step(); chk("xfer_drop", {7'd0, code_valid}, 8'd0);
        chk("ovf_sticky", {7'd0, overflow}, 8'd1);
        wait_quiet("h6f_lost", 3);

        // Invalid pattern
        segs_in = 7'h7F;
        wait_quiet("h7f_wait", 4);
        step(); chk_out("h7f_evt", 1'b1, 3'd7, 1'b1);
`ifdef SEGRX_ERRCNT_EN
        chk("errcnt_1", err_count, 8'd1);
`endif
        wait_quiet("h7f_done", 1);
`ifdef SEGRX_ERRCNT_EN
        for (int k = 0; k < 300; k++) begin
            segs_in = k[0] ? 7'h7F : 7'h7E;
            repeat (4) step();
        end
        step(); step();
        chk("errcnt_sat", err_count, 8'd255);
`endif

        // Reset while a pattern is held: reported again after release
        segs_in = 7'h6F;
        wait_quiet("h6f_wait", 4);
        step(); chk_out("h6f_evt", 1'b1, 3'd4, 1'b0);
        wait_quiet("h6f_done", 1);
        rst = 1'b1; step();
        chk_out("rst2", 1'b0, 3'd0, 1'b0);
        chk("rst2_ovf", {7'd0, overflow}, 8'd0);
`ifdef SEGRX_ERRCNT_EN
        chk("rst2_errcnt", err_count, 8'd0);
`endif
        rst = 1'b0;
        wait_quiet("h6f_rearm", 4);
        step(); chk_out("h6f_again", 1'b1, 3'd4, 1'b0);
        wait_quiet("h6f_again_done", 1);

        // Reset on the edge that would load a pending event discards it
        segs_in = 7'h3C;
        wait_quiet("pend_wait", 4);
        rst = 1'b1; step();
        chk_out("pend_discard", 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        wait_quiet("pend_rearm", 4);
        step(); chk_out("pend_again", 1'b1, 3'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_pattern_rx.md
SEG_PATTERN_RX -- requirements
Module: seg_pattern_rx

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, legal 2..255: consecutive identical samples required to accept a pattern.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 segs_in  input  7  seven-segment line levels, bit 6 = MSB; asynchronous to clk content-wise, sampled only.
REQ-005 out_ready  input  1  consumer ready for code.
REQ-006 code_valid  output  1  code/code_invalid hold an unconsumed event.
REQ-007 code  output  3  decoded class of accepted pattern.
REQ-008 code_invalid  output  1  accepted pattern not in decode table.
REQ-009 overflow  output  1  sticky; an event was dropped.

Function
REQ-010 segs_in SHALL be registered once (seg_q) each edge; all decisions use seg_q.
REQ-011 Stability counter (8 bit): load 1 when the newly sampled value differs from current seg_q, else increment, saturating at STABLE_CYCLES.
REQ-012 FSM states: WAIT (counter < STABLE_CYCLES), ARMED (pattern stable and already processed); any seg_q change returns to WAIT.
REQ-013 Accept event: on the edge where counter reaches STABLE_CYCLES, if no pattern reported since reset or seg_q != last_rep; last_rep <= seg_q.
REQ-014 Identical pattern re-stabilising after a glitch (P, Q, P) SHALL produce an event only if Q was itself accepted.
REQ-015 Decode table (seg_q hex -> code): 0x3C->0, 0x6E->1, 0x4F->2, 0x5B->3, 0x6F->4; code_invalid=0 for these.
REQ-016 Any other pattern -> code=7, code_invalid=1.
REQ-017 Accepted event loads output register on the next edge: code_valid rises on the edge after the STABLE_CYCLES-th identical sample.
REQ-018 Handshake: transfer when code_valid & out_ready at an edge; code/code_invalid SHALL not change while code_valid & !out_ready.
REQ-019 After transfer code_valid drops next edge unless a new event loads the same edge (then stays high with new data).
REQ-020 Event while code_valid & !out_ready: event dropped, register unchanged, overflow <= 1, last_rep still updated.
REQ-021 overflow SHALL remain 1 until reset.
REQ-022 out_ready while code_valid=0 has no effect.

Reset
REQ-023 rst at an edge: seg_q=0, counter=0, state WAIT, code_valid=0, code=0, code_invalid=0, overflow=0, "reported" flag cleared.
REQ-024 rst has priority over all events, including a same-edge transfer or acceptance; a pending event is discarded.
REQ-025 First stable pattern after reset SHALL be reported even if equal to the pre-reset last_rep.

Configuration
REQ-026 Macro SEGRX_ERRCNT_EN defined: extra output err_count (8 bit), increments on each accepted event with invalid pattern (including dropped ones), saturates at 255, reset to 0.
REQ-027 SEGRX_ERRCNT_EN undefined: no err_count port, no counter; all other behaviour identical.

Verification (STABLE_CYCLES=4)
REQ-028 Reset, hold segs_in=0x5B, out_ready=1 -> code_valid high one cycle, 5 edges after first sampling edge, code=3, code_invalid=0; no further events while held.
REQ-029 segs_in 0x3C for 3 edges, 0x6E 1 edge, 0x3C held -> single event code=0 only after 4 consecutive 0x3C samples.
REQ-030 out_ready=0; stabilise 0x4F then 0x6F -> code=2 held, overflow=1, 0x6F event lost; raise out_ready -> one transfer, code_valid drops.
REQ-031 Stabilise 0x7F -> code=7, code_invalid=1; with SEGRX_ERRCNT_EN err_count=1; 300 alternating invalid events -> err_count=255.
REQ-032 Stabilise 0x6F, consumed; assert rst 1 edge while 0x6F held -> outputs cleared, 0x6F reported again 5 edges after rst release.
